// File: rtl/bht_ghr_ctrl_pkg.sv
// bht_ghr_ctrl_pkg: shared history types and default sizes for the GHR controller.
package bht_ghr_ctrl_pkg;
  localparam int GHR_BITS    = 4;
  localparam int NR_GHR_CKPT = 8;
  typedef logic [GHR_BITS-1:0] ghr_t;
  typedef struct packed {
    logic valid;
    logic taken;
    logic mispredict;
  } bht_ghr_resolve_t;
endpackage

// File: rtl/bht_ghr_ctrl_ckpt_fifo.sv
// ghr_ckpt_fifo: in-order checkpoint FIFO of history snapshots; clear wins over push/pop.
module ghr_ckpt_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         push_data,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] rd, wr;
  logic do_push, do_pop;
  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign head    = mem[rd];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem   <= '{default: '0};
      rd    <= '0;
      wr    <= '0;
      count <= '0;
    end else if (clear) begin
      rd    <= wr;
      count <= '0;
    end else begin
      if (do_push) mem[wr] <= push_data;
      wr    <= do_push ? wr + AW'(1) : wr;
      rd    <= do_pop ? rd + AW'(1) : rd;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/bht_ghr_ctrl.sv
// bht_ghr_ctrl: speculative/committed global history with per-branch checkpoints for the BHT.
// Optional perf counters are enabled with BHT_GHR_PERF_CNT_EN.
module bht_ghr_ctrl
  import bht_ghr_ctrl_pkg::*;
#(
  parameter int GHR_BITS = bht_ghr_ctrl_pkg::GHR_BITS,
  parameter int NR_CKPT  = bht_ghr_ctrl_pkg::NR_GHR_CKPT
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       debug_mode_i,
  input  logic                       predict_valid_i,
  input  logic                       predict_taken_i,
  output logic                       predict_ready_o,
  output logic [GHR_BITS-1:0]        ghr_o,
  input  logic                       resolve_valid_i,
  input  logic                       resolve_taken_i,
  input  logic                       resolve_mispredict_i,
  output logic [GHR_BITS-1:0]        update_ghr_o,
  output logic                       update_valid_o,
  output logic [$clog2(NR_CKPT):0]   ckpt_count_o
`ifdef BHT_GHR_PERF_CNT_EN
  ,
  output logic [31:0]                perf_resolve_cnt_o,
  output logic [31:0]                perf_mispredict_cnt_o
`endif
);
  localparam int CW = $clog2(NR_CKPT) + 1;
  bht_ghr_resolve_t res;
  logic [GHR_BITS-1:0] spec_q, spec_d, commit_q, commit_d, commit_sh;
  logic pred_acc, mis, empty, full;
  assign res             = '{valid: resolve_valid_i, taken: resolve_taken_i, mispredict: resolve_mispredict_i};
  assign ghr_o           = spec_q;
  assign predict_ready_o = ckpt_count_o != CW'(NR_CKPT);
  assign update_valid_o  = res.valid && !empty && !debug_mode_i;
  assign pred_acc        = predict_valid_i && predict_ready_o && !debug_mode_i;
  assign mis             = update_valid_o && res.mispredict;
  assign commit_sh       = {commit_q[GHR_BITS-2:0], res.taken};
  // A mispredict rebuilds history from the committed copy; younger predicts are squashed.
  always_comb begin
    spec_d   = flush_i ? commit_q :
               mis     ? commit_sh :
               pred_acc ? {spec_q[GHR_BITS-2:0], predict_taken_i} : spec_q;
    commit_d = (update_valid_o && !flush_i) ? commit_sh : commit_q;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      spec_q   <= '0;
      commit_q <= '0;
    end else begin
      spec_q   <= spec_d;
      commit_q <= commit_d;
    end
  end
  ghr_ckpt_fifo #(.WIDTH(GHR_BITS), .DEPTH(NR_CKPT)) u_fifo (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clear     (flush_i || mis),
    .push      (pred_acc),
    .pop       (update_valid_o),
    .push_data (spec_q),
    .head      (update_ghr_o),
    .count     (ckpt_count_o),
    .full      (full),
    .empty     (empty)
  );
`ifdef BHT_GHR_PERF_CNT_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_resolve_cnt_o    <= '0;
      perf_mispredict_cnt_o <= '0;
    end else begin
      perf_resolve_cnt_o    <= perf_resolve_cnt_o + 32'(update_valid_o);
      perf_mispredict_cnt_o <= perf_mispredict_cnt_o + 32'(mis);
    end
  end
`endif
endmodule

// File: tb/tb_bht_ghr_ctrl.sv
// tb_bht_ghr_ctrl: table-driven directed vectors plus reset sequences for bht_ghr_ctrl.
module tb_bht_ghr_ctrl;
  logic clk = 0, rst_ni = 0;
  logic flush, dbg, pv, pt, rv, rt, rm;
  logic rdy, uv;
  logic [3:0] ghr, ughr, cnt;
  int n_chk = 0, n_pass = 0;
  typedef struct {
    logic [6:0] in;
    logic rdy;
    logic [3:0] ghr;
    logic [3:0] cnt;
    logic uv;
    logic uc;
    logic [3:0] ughr;
  } vec_t;
  vec_t vecs[$];
  always #5 clk = ~clk;
  bht_ghr_ctrl dut (
    .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush), .debug_mode_i(dbg),
    .predict_valid_i(pv), .predict_taken_i(pt), .predict_ready_o(rdy), .ghr_o(ghr),
    .resolve_valid_i(rv), .resolve_taken_i(rt), .resolve_mispredict_i(rm),
    .update_ghr_o(ughr), .update_valid_o(uv), .ckpt_count_o(cnt)
  );
  function automatic vec_t mk(logic [6:0] i, logic r, logic [3:0] g, logic [3:0] c,
                              logic u, logic uc, logic [3:0] ug);
    vec_t v;
    v.in = i; v.rdy = r; v.ghr = g; v.cnt = c; v.uv = u; v.uc = uc; v.ughr = ug;
    return v;
  endfunction
  task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
  endtask
  task automatic drive(logic [6:0] i);
    {flush, dbg, pv, pt, rv, rt, rm} = i;
  endtask
  task automatic check_idle(string tag, logic [3:0] g);
    chk({tag, "_ghr"}, 0, 32'(ghr), 32'(g));
    chk({tag, "_cnt"}, 0, 32'(cnt), 0);
    chk({tag, "_rdy"}, 0, 32'(rdy), 1);
    chk({tag, "_uv"}, 0, 32'(uv), 0);
  endtask
  initial begin
    // inputs: {flush, dbg, pv, pt, rv, rt, rm}
    vecs.push_back(mk(7'b0000000, 1, 4'b0000, 0, 0, 1, 4'b0000));
    vecs.push_back(mk(7'b0011000, 1, 4'b0000, 0, 0, 1, 4'b0000));
    vecs.push_back(mk(7'b0011000, 1, 4'b0001, 1, 0, 1, 4'b0000));
    vecs.push_back(mk(7'b0011000, 1, 4'b0011, 2, 0, 1, 4'b0000));
    vecs.push_back(mk(7'b0000110, 1, 4'b0111, 3, 1, 1, 4'b0000));
    vecs.push_back(mk(7'b0011101, 1, 4'b0111, 2, 1, 1, 4'b0001));
    vecs.push_back(mk(7'b0000000, 1, 4'b0010, 0, 0, 0, 4'b0000));
    vecs.push_back(mk(7'b0111110, 1, 4'b0010, 0, 0, 0, 4'b0000));
    vecs.push_back(mk(7'b0011000, 1, 4'b0010, 0, 0, 0, 4'b0000));
    vecs.push_back(mk(7'b0010000, 1, 4'b0101, 1, 0, 1, 4'b0010));
    vecs.push_back(mk(7'b0011000, 1, 4'b1010, 2, 0, 1, 4'b0010));
    vecs.push_back(mk(7'b0010000, 1, 4'b0101, 3, 0, 1, 4'b0010));
    vecs.push_back(mk(7'b0011000, 1, 4'b1010, 4, 0, 1, 4'b0010));
    vecs.push_back(mk(7'b0010000, 1, 4'b0101, 5, 0, 1, 4'b0010));
    vecs.push_back(mk(7'b0011000, 1, 4'b1010, 6, 0, 1, 4'b0010));
    vecs.push_back(mk(7'b0010000, 1, 4'b0101, 7, 0, 1, 4'b0010));
    vecs.push_back(mk(7'b0011000, 0, 4'b1010, 8, 0, 1, 4'b0010));
    vecs.push_back(mk(7'b0011110, 0, 4'b1010, 8, 1, 1, 4'b0010));
    vecs.push_back(mk(7'b0000000, 1, 4'b1010, 7, 0, 1, 4'b0101));
    vecs.push_back(mk(7'b0000100, 1, 4'b1010, 7, 1, 1, 4'b0101));
    vecs.push_back(mk(7'b0000100, 1, 4'b1010, 6, 1, 1, 4'b1010));
    vecs.push_back(mk(7'b0000100, 1, 4'b1010, 5, 1, 1, 4'b0101));
    vecs.push_back(mk(7'b0011110, 1, 4'b1010, 4, 1, 1, 4'b1010));
    vecs.push_back(mk(7'b0000000, 1, 4'b0101, 4, 0, 1, 4'b0101));
    vecs.push_back(mk(7'b1011110, 1, 4'b0101, 4, 1, 1, 4'b0101));
    vecs.push_back(mk(7'b0000110, 1, 4'b0001, 0, 0, 0, 4'b0000));
    vecs.push_back(mk(7'b0010000, 1, 4'b0001, 0, 0, 0, 4'b0000));
    vecs.push_back(mk(7'b0000111, 1, 4'b0010, 1, 1, 1, 4'b0001));
    vecs.push_back(mk(7'b0000000, 1, 4'b0011, 0, 0, 0, 4'b0000));
    drive(7'b0);
    #1;
    check_idle("rst_async", 4'b0000);
    chk("rst_ughr", 0, 32'(ughr), 0);
    repeat (2) @(negedge clk);
    rst_ni = 1;
    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].in);
      #1;
      chk("ready", i, 32'(rdy), 32'(vecs[i].rdy));
      chk("ghr", i, 32'(ghr), 32'(vecs[i].ghr));
      chk("count", i, 32'(cnt), 32'(vecs[i].cnt));
      chk("uvalid", i, 32'(uv), 32'(vecs[i].uv));
      if (vecs[i].uc) chk("ughr", i, 32'(ughr), 32'(vecs[i].ughr));
    end
    // History 0011 with empty FIFO; two taken predicts then async reset mid-cycle.
    repeat (2) begin
      @(negedge clk);
      drive(7'b0011000);
    end
    @(negedge clk);
    drive(7'b0);
    #1;
    chk("pre_rst_ghr", 0, 32'(ghr), 32'(4'b1111));
    chk("pre_rst_cnt", 0, 32'(cnt), 2);
    #2 rst_ni = 0;
    #1;
    check_idle("mid_rst", 4'b0000);
    @(negedge clk);
    rst_ni = 1;
    @(negedge clk);
    drive(7'b0011000);
    @(negedge clk);
    drive(7'b0);
    #1;
    chk("post_rst_ghr", 0, 32'(ghr), 32'(4'b0001));
    chk("post_rst_cnt", 0, 32'(cnt), 1);
    chk("post_rst_ughr", 0, 32'(ughr), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
